// File: rtl/mem_word_uart_tx_if.sv
// Bus bundle between the core's memory-mapped word port and the UART hex transmitter.
interface mem_word_uart_tx_if;
  logic [31:0] i_mem_word;
  logic        i_send;
  logic        o_tx;
  logic        o_busy;
  logic        o_done;

  modport master (output i_mem_word, output i_send, input o_tx, input o_busy, input o_done);
  modport slave  (input i_mem_word, input i_send, output o_tx, output o_busy, output o_done);
endinterface

// File: rtl/mem_word_uart_tx.sv
// Sends a 32-bit word as "XXXXXXXX\r\n" (uppercase hex, MSN first) over a UART 8N1 line.
// Optional MEM_WORD_AUTO_SEND_EN also starts a frame whenever the word differs from the last one sent.
module mem_word_uart_tx #(
  parameter int P_CLKS_PER_BIT = 868
) (
  input  logic               i_clk,
  input  logic               i_rst_p,
  mem_word_uart_tx_if.slave  bus
);

  localparam int CNT_W = (P_CLKS_PER_BIT > 1) ? $clog2(P_CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) hex_ascii = 8'h30 + {4'h0, nib};
    else             hex_ascii = 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [31:0] word, input logic [3:0] idx);
    case (idx)
      4'd0:    frame_byte = hex_ascii(word[31:28]);
      4'd1:    frame_byte = hex_ascii(word[27:24]);
      4'd2:    frame_byte = hex_ascii(word[23:20]);
      4'd3:    frame_byte = hex_ascii(word[19:16]);
      4'd4:    frame_byte = hex_ascii(word[15:12]);
      4'd5:    frame_byte = hex_ascii(word[11:8]);
      4'd6:    frame_byte = hex_ascii(word[7:4]);
      4'd7:    frame_byte = hex_ascii(word[3:0]);
      4'd8:    frame_byte = 8'h0D;
      default: frame_byte = 8'h0A;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [31:0]      word_r, word_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_r, bit_s;
  logic [3:0]       byte_r, byte_s;
  logic [7:0]       cur_byte_s;
  logic             tx_r, tx_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             accept_s;
  logic             cnt_end_s;

`ifdef MEM_WORD_AUTO_SEND_EN
  logic [31:0] last_sent_r;

  assign accept_s = (state_r == S_IDLE) && (bus.i_send || (bus.i_mem_word != last_sent_r));

  // Remember the word carried by the most recent accepted frame.
  always_ff @(posedge i_clk) begin
    if (i_rst_p) begin
      last_sent_r <= 32'h0000_0000;
    end else if (accept_s) begin
      last_sent_r <= bus.i_mem_word;
    end
  end
`else
  assign accept_s = (state_r == S_IDLE) && bus.i_send;
`endif

  assign cnt_end_s = (cnt_r == CNT_LAST);

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_s = state_r;
    word_s  = word_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    byte_s  = byte_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_START;
          word_s  = bus.i_mem_word;
          cnt_s   = '0;
          bit_s   = 3'd0;
          byte_s  = 4'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_end_s) begin
          cnt_s   = '0;
          bit_s   = 3'd0;
          state_s = S_DATA;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_end_s) begin
          cnt_s = '0;
          if (bit_r == 3'd7) state_s = S_STOP;
          else               bit_s   = bit_r + 3'd1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_end_s) begin
          cnt_s = '0;
          if (byte_r < 4'd9) begin
            byte_s  = byte_r + 4'd1;
            state_s = S_START;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        bit_s   = 3'd0;
        byte_s  = 4'd0;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        bit_s   = 3'd0;
        byte_s  = 4'd0;
      end
    endcase

    cur_byte_s = frame_byte(word_s, byte_s);
    case (state_s)
      S_START: tx_s = 1'b0;
      S_DATA:  tx_s = cur_byte_s[bit_s];
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s == S_START) || (state_s == S_DATA) || (state_s == S_STOP);
    done_s = (state_s == S_DONE);
  end

  // State, counters and registered line outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst_p) begin
      state_r <= S_IDLE;
      word_r  <= 32'h0000_0000;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      byte_r  <= 4'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      word_r  <= word_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      byte_r  <= byte_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.o_tx   = tx_r;
  assign bus.o_busy = busy_r;
  assign bus.o_done = done_r;

endmodule

// File: doc/mem_word_uart_tx.md
MEM_WORD_UART_TX -- requirements
Module: mem_word_uart_tx

Interface
REQ-001 SHALL have parameter P_CLKS_PER_BIT, default 868, i_clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.
REQ-002 SHALL have port i_clk  input  1  single clock for all logic, rising edge.
REQ-003 SHALL have port i_rst_p  input  1  reset, synchronous to i_clk, active-high.
REQ-004 SHALL have port i_mem_word  input  32  memory-mapped word from the single-cycle core.
REQ-005 SHALL have port i_send  input  1  one-cycle request pulse, already debounced, synchronised and one-period.
REQ-006 SHALL have port o_tx  output  1  UART line, 8N1, idle high.
REQ-007 SHALL have port o_busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-009 SHALL use one clock and one synchronous active-high reset: i_clk and i_rst_p.
REQ-010 SHALL accept a request in IDLE when i_send=1, snapshotting i_mem_word on that edge; later changes to i_mem_word SHALL NOT alter the frame.
REQ-011 SHALL transmit a frame of 10 bytes: 8 uppercase ASCII hex digits, most-significant nibble first ("0"-"9"=0x30-0x39, "A"-"F"=0x41-0x46), then 0x0D, then 0x0A.
REQ-012 SHALL send each byte as start bit (0), 8 data bits LSB first, then stop bit (1), with each bit held exactly P_CLKS_PER_BIT cycles and no idle gap between bytes.
REQ-013 SHALL drive the start bit of byte 0 on o_tx from the cycle after acceptance; o_busy SHALL rise in that same cycle.
REQ-014 SHALL make the frame length exactly 100*P_CLKS_PER_BIT cycles of o_busy=1.
REQ-015 SHALL use FSM states IDLE -> START -> DATA (8 bits) -> STOP -> {START if byte index < 9, else DONE} -> IDLE; DONE SHALL last one cycle.
REQ-016 SHALL pulse o_done for exactly one cycle in DONE, with o_busy=0 and o_tx=1 in that cycle.
REQ-017 SHALL ignore i_send while o_busy=1 or in DONE; requests are not queued.
REQ-018 SHALL use a bit-period counter sized ceil(log2(P_CLKS_PER_BIT)) bits wrapping at P_CLKS_PER_BIT-1, a 3-bit data bit index, and a 4-bit byte index 0..9.

Reset
REQ-019 SHALL, with i_rst_p=1 on a clock edge, force o_tx=1, o_busy=0, o_done=0, FSM=IDLE, and all counters=0 on that edge.
REQ-020 SHALL abort a frame in progress when reset is asserted mid-frame; o_tx SHALL return high on the reset edge, and no o_done SHALL be produced.
REQ-021 SHALL give i_rst_p priority over i_send on the same edge.

Configuration
REQ-022 SHALL support macro MEM_WORD_AUTO_SEND_EN.
REQ-023 With MEM_WORD_AUTO_SEND_EN defined, SHALL keep a 32-bit last-sent register (reset 0x00000000), updated at every acceptance, and SHALL also accept a request in IDLE whenever i_mem_word differs from it; a change occurring during a frame SHALL be sent after DONE, carrying the value current at that acceptance.
REQ-024 Without MEM_WORD_AUTO_SEND_EN, SHALL start frames only on i_send, and no last-sent register SHALL exist.

Verification (P_CLKS_PER_BIT=4)
REQ-025 Basic frame: i_mem_word=0x000000A5, i_send pulse -> bytes 0x30 x6, 0x41, 0x35, 0x0D, 0x0A; o_busy high 400 cycles; o_done pulses once.
REQ-026 Digit/letter boundary: word 0x9AF0_0F9A -> "9AF00F9A\r\n"; each bit sampled mid-period matches.
REQ-027 Snapshot and ignore: send 0x12345678, change the word to 0xFFFFFFFF at cycle 50, pulse i_send at cycle 60 -> exactly one frame "12345678\r\n" and no second frame.
REQ-028 Mid-frame reset: assert i_rst_p at cycle 150 for 1 cycle -> o_tx=1 and o_busy=0 next cycle, no o_done; a later i_send gives a complete frame.
REQ-029 Simultaneous: i_rst_p and i_send high on the same edge -> stays IDLE, o_tx=1.
REQ-030 With MEM_WORD_AUTO_SEND_EN: after reset, word goes 0 -> 0x00000001 -> frame "00000001\r\n" with no i_send; change to 0x2 mid-frame -> second frame "00000002\r\n" starts the cycle after o_done.
